// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    localparam int unsigned WIDTH = 16;
    localparam logic [WIDTH-1:0] DEFAULT_RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        LOAD = 2'd2
    } state_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter register: reset has priority over branch load, which has priority over increment.
module pc_reg
    import fetch_pkg::*;
#(
    parameter logic [WIDTH-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             inc,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] pc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= target;
        end else if (inc) begin
            pc <= pc + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch FSM (IDLE/REQ/LOAD): one memory read per start, branch redirect wins over ack.
// Define FETCH_TIMEOUT_EN to abort a fetch after TIMEOUT_CYCLES cycles without mem_ack (sticky err).
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [WIDTH-1:0] RESET_PC       = DEFAULT_RESET_PC,
    parameter int unsigned      TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stall,
    input  logic             br_valid,
    input  logic [WIDTH-1:0] br_target,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             mem_req,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] instr,
    output logic             en_ir,
    output logic [WIDTH-1:0] pc,
    output logic             busy,
    output logic             err
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("fetch_unit: TIMEOUT_CYCLES must be in 1..255");
    end

    state_t state;
    logic   pc_inc;

    // A branch redirect suppresses the increment even when the ack lands in the same cycle.
    assign pc_inc   = (state == REQ) && mem_ack && !br_valid;
    assign mem_addr = pc;

    pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .clk    (clk),
        .rst    (rst),
        .load   (br_valid),
        .inc    (pc_inc),
        .target (br_target),
        .pc     (pc)
    );

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] tcount;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            instr   <= '0;
            mem_req <= 1'b0;
            en_ir   <= 1'b0;
            busy    <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            err     <= 1'b0;
            tcount  <= '0;
`endif
        end else begin
            en_ir <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !stall && !br_valid) begin
                        state   <= REQ;
                        mem_req <= 1'b1;
                        busy    <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
                        tcount  <= '0;
`endif
                    end
                end
                REQ: begin
                    if (br_valid) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        busy    <= 1'b0;
                    end else if (mem_ack) begin
                        instr   <= mem_rdata;
                        state   <= LOAD;
                        mem_req <= 1'b0;
                        en_ir   <= 1'b1;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (tcount == TIMEOUT_LAST) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        busy    <= 1'b0;
                        err     <= 1'b1;
                    end else begin
                        tcount  <= tcount + 8'd1;
                    end
`endif
                end
                LOAD: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: expected (instr, pc) pushed at ack, popped on each en_ir strobe.
// Timeout expectations follow FETCH_TIMEOUT_EN as defined for the build.
module tb_fetch_unit;

    localparam logic [15:0] RST_PC = 16'h0000;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        br_valid = 1'b0;
    logic [15:0] br_target = 16'h0000;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = 16'h0000;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] instr;
    logic        en_ir;
    logic [15:0] pc;
    logic        busy;
    logic        err;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned n_load   = 0;
    int unsigned n_expect = 0;
    exp_t        sb[$];
    logic [15:0] model_pc    = RST_PC;
    logic [15:0] model_instr = 16'h0000;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC       (RST_PC),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stall     (stall),
        .br_valid  (br_valid),
        .br_target (br_target),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .instr     (instr),
        .en_ir     (en_ir),
        .pc        (pc),
        .busy      (busy),
        .err       (err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && en_ir === 1'b1) begin
            n_load++;
            if (sb.size() == 0) begin
                check_eq("en_ir_unexpected", 32'(en_ir), 32'd0);
            end else begin
                e = sb.pop_front();
                check_eq("instr_at_load", 32'(instr), 32'(e.instr));
                check_eq("pc_at_load", 32'(pc), 32'(e.pc));
            end
        end
    end

    // One complete fetch; optionally keep start high while in REQ and/or branch during LOAD.
    task automatic fetch(input int unsigned wait_cycles, input logic [15:0] data,
                         input bit hold_start, input bit br_load, input logic [15:0] tgt);
        exp_t e;
        start = 1'b1;
        tick();
        if (!hold_start) start = 1'b0;
        check_eq("mem_req_on", 32'(mem_req), 32'd1);
        check_eq("mem_addr", 32'(mem_addr), 32'(model_pc));
        for (int unsigned i = 0; i < wait_cycles; i++) begin
            tick();
            check_eq("mem_req_hold", 32'(mem_req), 32'd1);
        end
        start     = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = data;
        e.instr   = data;
        e.pc      = model_pc + 16'd1;
        sb.push_back(e);
        n_expect++;
        tick();
        mem_ack     = 1'b0;
        model_pc    = model_pc + 16'd1;
        model_instr = data;
        check_eq("en_ir_strobe", 32'(en_ir), 32'd1);
        check_eq("mem_req_off", 32'(mem_req), 32'd0);
        if (br_load) begin
            br_valid  = 1'b1;
            br_target = tgt;
        end
        tick();
        br_valid = 1'b0;
        if (br_load) model_pc = tgt;
        check_eq("en_ir_one_cycle", 32'(en_ir), 32'd0);
        check_eq("busy_idle", 32'(busy), 32'd0);
        check_eq("pc_after_fetch", 32'(pc), 32'(model_pc));
    endtask

    initial begin
        int unsigned drops;
        int unsigned loads_before;

        tick();
        tick();
        rst = 1'b0;
        check_eq("rst_pc", 32'(pc), 32'(RST_PC));
        check_eq("rst_instr", 32'(instr), 32'd0);
        check_eq("rst_mem_req", 32'(mem_req), 32'd0);
        check_eq("rst_en_ir", 32'(en_ir), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);

        // Basic fetch with three wait cycles.
        fetch(3, 16'hA5C3, 1'b0, 1'b0, 16'h0000);
        check_eq("instr_a5c3", 32'(instr), 32'h0000A5C3);

        // Branch in IDLE to the top of memory, then fetch wraps the PC.
        br_valid  = 1'b1;
        br_target = 16'hFFFF;
        tick();
        br_valid = 1'b0;
        model_pc = 16'hFFFF;
        check_eq("br_idle_pc", 32'(pc), 32'h0000FFFF);
        check_eq("br_idle_busy", 32'(busy), 32'd0);
        fetch(0, 16'h1234, 1'b0, 1'b0, 16'h0000);
        check_eq("pc_wrap", 32'(pc), 32'h00000000);

        // Branch and ack in the same REQ cycle: branch wins, data discarded.
        loads_before = n_load;
        start = 1'b1;
        tick();
        start     = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 16'hDEAD;
        br_valid  = 1'b1;
        br_target = 16'h0040;
        tick();
        mem_ack  = 1'b0;
        br_valid = 1'b0;
        model_pc = 16'h0040;
        check_eq("br_ack_mem_req", 32'(mem_req), 32'd0);
        check_eq("br_ack_busy", 32'(busy), 32'd0);
        check_eq("br_ack_pc", 32'(pc), 32'h00000040);
        check_eq("br_ack_instr", 32'(instr), 32'(model_instr));
        tick();
        tick();
        check_eq("br_ack_no_en_ir", n_load, loads_before);

        // Start with stall is dropped, not queued; start with branch in IDLE is ignored.
        start = 1'b1;
        stall = 1'b1;
        tick();
        check_eq("stall_mem_req", 32'(mem_req), 32'd0);
        start = 1'b0;
        stall = 1'b0;
        tick();
        check_eq("stall_not_queued", 32'(mem_req), 32'd0);
        start     = 1'b1;
        br_valid  = 1'b1;
        br_target = 16'h2000;
        tick();
        start    = 1'b0;
        br_valid = 1'b0;
        model_pc = 16'h2000;
        check_eq("start_br_mem_req", 32'(mem_req), 32'd0);
        check_eq("start_br_pc", 32'(pc), 32'h00002000);

        // Start held through REQ is ignored; branch during LOAD keeps the strobe.
        loads_before = n_load;
        fetch(2, 16'h5A5A, 1'b1, 1'b1, 16'h1000);
        tick();
        check_eq("no_second_fetch", 32'(mem_req), 32'd0);
        check_eq("single_load", n_load, loads_before + 1);

        // Reset mid-REQ; a late ack must be ignored.
        loads_before = n_load;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst         = 1'b0;
        model_pc    = RST_PC;
        model_instr = 16'h0000;
        check_eq("mid_rst_mem_req", 32'(mem_req), 32'd0);
        check_eq("mid_rst_pc", 32'(pc), 32'(RST_PC));
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 16'hBEEF;
        tick();
        mem_ack = 1'b0;
        tick();
        check_eq("late_ack_mem_req", 32'(mem_req), 32'd0);
        check_eq("late_ack_instr", 32'(instr), 32'd0);
        check_eq("late_ack_pc", 32'(pc), 32'(RST_PC));
        check_eq("late_ack_no_load", n_load, loads_before);

        // Fetch with no ack at all.
        start = 1'b1;
        tick();
        start = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        for (int unsigned i = 0; i < 4; i++) begin
            check_eq("to_mem_req_held", 32'(mem_req), 32'd1);
            check_eq("to_err_low", 32'(err), 32'd0);
            tick();
        end
        check_eq("to_mem_req_drop", 32'(mem_req), 32'd0);
        check_eq("to_err_set", 32'(err), 32'd1);
        check_eq("to_busy", 32'(busy), 32'd0);
        check_eq("to_pc", 32'(pc), 32'(model_pc));
        fetch(0, 16'h0F0F, 1'b0, 1'b0, 16'h0000);
        check_eq("to_err_sticky", 32'(err), 32'd1);
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        model_pc = RST_PC;
        check_eq("to_err_cleared", 32'(err), 32'd0);
`else
        drops = 0;
        for (int unsigned i = 0; i < 300; i++) begin
            if (mem_req !== 1'b1 || err !== 1'b0) drops++;
            tick();
        end
        check_eq("no_to_mem_req_held", drops, 32'd0);
        check_eq("no_to_err", 32'(err), 32'd0);
        br_valid  = 1'b1;
        br_target = 16'h0100;
        tick();
        br_valid = 1'b0;
        model_pc = 16'h0100;
        check_eq("no_to_br_exit", 32'(mem_req), 32'd0);
        check_eq("no_to_br_pc", 32'(pc), 32'h00000100);
`endif

        tick();
        tick();
        check_eq("sb_empty", sb.size(), 32'd0);
        check_eq("load_count", n_load, n_expect);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, PC value loaded on reset.
REQ-002 Parameter TIMEOUT_CYCLES, default 255, cycles without mem_ack before abort; range 1..255, used only with FETCH_TIMEOUT_EN.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  control requests one instruction fetch.
REQ-006 stall  input  1  inhibits starting a new fetch.
REQ-007 br_valid  input  1  redirect PC this cycle.
REQ-008 br_target  input  16  redirect address.
REQ-009 mem_ack  input  1  memory returns mem_rdata this cycle.
REQ-010 mem_rdata  input  16  instruction word from memory.
REQ-011 mem_req  output  1  memory read request, level, held until ack or abort.
REQ-012 mem_addr  output  16  read address; equals pc while mem_req=1.
REQ-013 instr  output  16  fetched word; drives the instruction register data input.
REQ-014 en_ir  output  1  one-cycle load strobe for the instruction register.
REQ-015 pc  output  16  current program counter.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 err  output  1  sticky fetch-timeout flag.

Function
REQ-018 FSM states SHALL be IDLE, REQ, LOAD.
REQ-019 IDLE->REQ SHALL occur when start=1, stall=0 and br_valid=0; mem_req asserts in the cycle after start is sampled.
REQ-020 In REQ, mem_req=1 and mem_addr=pc; on mem_ack=1 with br_valid=0, instr<=mem_rdata, pc<=pc+1, next state LOAD.
REQ-021 In LOAD, en_ir=1 for exactly one cycle, mem_req=0; next state IDLE unconditionally; start-to-en_ir latency = 2 cycles + memory wait.
REQ-022 PC increment SHALL be modulo 2^16 (16'hFFFF+1 = 16'h0000).
REQ-023 br_valid=1 in IDLE or LOAD SHALL load pc<=br_target and leave state unchanged (LOAD still strobes en_ir).
REQ-024 br_valid=1 in REQ SHALL drop mem_req next cycle, set pc<=br_target, return to IDLE, no en_ir; this holds also when mem_ack=1 in the same cycle (branch wins, data discarded).
REQ-025 start while busy=1 SHALL be ignored; start with stall=1 in IDLE SHALL be ignored, not queued.
REQ-026 instr SHALL hold its value except on the capture in REQ-020.

Reset
REQ-027 rst=1 SHALL force state IDLE, pc=RESET_PC, instr=16'h0000, mem_req=0, en_ir=0, busy=0, err=0, timeout count=0, overriding all other inputs, including mid-fetch.

Configuration
REQ-028 Macro FETCH_TIMEOUT_EN defined: an 8-bit counter clears on REQ entry, increments each REQ cycle without mem_ack; reaching TIMEOUT_CYCLES SHALL drop mem_req, set err=1 (sticky until rst), pc unchanged, return to IDLE.
REQ-029 FETCH_TIMEOUT_EN undefined: no counter; err tied 0; REQ waits indefinitely for mem_ack or br_valid.

Structure
REQ-030 Package fetch_pkg SHALL hold the state encoding constants (IDLE, REQ, LOAD), the 16-bit width constant and the default RESET_PC.
REQ-031 One sub-module, pc_reg, SHALL hold the PC with synchronous load (branch), increment and reset inputs.

Verification
REQ-032 rst, then start=1 one cycle, mem_ack after 3 REQ cycles with mem_rdata=16'hA5C3 -> mem_addr=16'h0000, instr=16'hA5C3, one en_ir pulse, pc=16'h0001.
REQ-033 br_valid=1, br_target=16'hFFFF in IDLE, then fetch with ack -> mem_addr=16'hFFFF, pc wraps to 16'h0000.
REQ-034 br_valid=1, br_target=16'h0040 and mem_ack=1 in same REQ cycle -> no en_ir, instr unchanged, pc=16'h0040, state IDLE.
REQ-035 start with stall=1, then start during REQ -> no mem_req from the first, no second fetch from the second.
REQ-036 rst=1 mid-REQ -> next cycle mem_req=0, pc=RESET_PC, busy=0; late mem_ack ignored.
REQ-037 FETCH_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, no ack -> mem_req drops after 4 REQ cycles, err=1 until rst; undefined build -> mem_req held 300 cycles, err=0.
